conv_window_gen: RTL and testbench

Upstream feeder for the convolution stage. Reads a 30x30 image of 48-bit pixels from the input ROM in raster order and emits one zero-padded 3x3 neighbourhood per pixel, 900 windows total, over a valid/ready handshake. Buffering uses a 2·IMG_W+3 deep pixel shift register. Throughput is one window per clock when the consumer never stalls.

---
 rtl/conv_window_gen.sv | 178 +++++++++++++++++
 tb/tb_conv_window_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// 3x3 zero-padded window generator over a raster-order ROM image, valid/ready output.
// Define WINGEN_EDGE_REPLICATE_EN to replace zero padding with nearest-pixel edge replication.
module conv_window_gen #(
  parameter int unsigned IMG_W  = 30,
  parameter int unsigned IMG_H  = 30,
  parameter int unsigned PIX_W  = 48,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 rom_en,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [PIX_W-1:0]     rom_data,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [9*PIX_W-1:0]   win_data,
  output logic [4:0]           win_row,
  output logic [4:0]           win_col,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned NPix  = IMG_W * IMG_H;
  localparam int unsigned Depth = 2 * IMG_W + 3;
  localparam int unsigned CntW  = $clog2(NPix + IMG_W + 2);

  localparam logic [ADDR_W-1:0] RdEnd    = ADDR_W'(NPix);
  localparam logic [CntW-1:0]   LastReal = CntW'(NPix - 1);
  localparam logic [CntW-1:0]   LastPush = CntW'(NPix + IMG_W);
  localparam logic [CntW-1:0]   FirstWin = CntW'(IMG_W + 1);
  localparam logic [4:0]        ColLast  = 5'(IMG_W - 1);
  localparam logic [4:0]        RowLast  = 5'(IMG_H - 1);

  typedef enum logic [2:0] {StIdle, StRead, StFlush, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_cnt_q;
  logic                rd_vld_q;
  logic                pend_q;
  logic [PIX_W-1:0]    pend_data_q;
  logic [CntW-1:0]     push_cnt_q;
  logic [4:0]          ctr_row_q, ctr_col_q;
  logic                win_valid_q;
  logic [9*PIX_W-1:0]  win_data_q;
  logic [4:0]          win_row_q, win_col_q;

  // The incoming pixel acts as stage 0 of the Depth-deep shift register.
  logic [PIX_W-1:0]    sr_q [Depth-1];
  logic [PIX_W-1:0]    nsr  [Depth];

  logic                can_push, push, load_win;
  logic [PIX_W-1:0]    push_data;
  logic [9*PIX_W-1:0]  win_next;

  always_comb begin
    can_push  = !win_valid_q || win_ready;
    push      = 1'b0;
    push_data = '0;
    if (pend_q) begin
      push      = can_push;
      push_data = pend_data_q;
    end else if (rd_vld_q) begin
      push      = can_push;
      push_data = rom_data;
    end else if (state_q == StFlush) begin
      push      = can_push;
    end
    load_win = push && (push_cnt_q >= FirstWin);
    rom_en   = (state_q == StRead) && (rd_cnt_q < RdEnd) && !pend_q && can_push;
  end

  always_comb begin
    nsr[0] = push_data;
    for (int t = 1; t < Depth; t++) begin
      nsr[t] = sr_q[t-1];
    end
  end

  // Tap 2W+2-i*W-j holds pixel (row-1+i, col-1+j) relative to the window centre.
  for (genvar i = 0; i < 3; i++) begin : g_row
    for (genvar j = 0; j < 3; j++) begin : g_col
      localparam int unsigned TapIJ = 2 * IMG_W + 2 - i * IMG_W - j;
      logic row_out, col_out;
      assign row_out = ((i == 0) && (ctr_row_q == 5'd0)) || ((i == 2) && (ctr_row_q == RowLast));
      assign col_out = ((j == 0) && (ctr_col_q == 5'd0)) || ((j == 2) && (ctr_col_q == ColLast));
`ifdef WINGEN_EDGE_REPLICATE_EN
      localparam int unsigned Tap1J = 2 * IMG_W + 2 - IMG_W - j;
      localparam int unsigned TapI1 = 2 * IMG_W + 2 - i * IMG_W - 1;
      localparam int unsigned Tap11 = IMG_W + 1;
      assign win_next[PIX_W*(3*i+j) +: PIX_W] =
          row_out ? (col_out ? nsr[Tap11] : nsr[Tap1J])
                  : (col_out ? nsr[TapI1] : nsr[TapIJ]);
`else
      assign win_next[PIX_W*(3*i+j) +: PIX_W] = (row_out || col_out) ? '0 : nsr[TapIJ];
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRead;
      StRead:  if (push && (push_cnt_q == LastReal)) state_d = StFlush;
      StFlush: if (push && (push_cnt_q == LastPush)) state_d = StDrain;
      StDrain: if (win_valid_q && win_ready) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rd_cnt_q    <= '0;
      rd_vld_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      push_cnt_q  <= '0;
      ctr_row_q   <= '0;
      ctr_col_q   <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      for (int t = 0; t < Depth - 1; t++) begin
        sr_q[t] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rd_vld_q <= rom_en;
      if ((state_q == StIdle) && start) begin
        rd_cnt_q   <= '0;
        push_cnt_q <= '0;
        ctr_row_q  <= '0;
        ctr_col_q  <= '0;
      end
      if (rom_en) rd_cnt_q <= rd_cnt_q + 1'b1;
      // A returning pixel that meets a stalled output parks in pend.
      if (rd_vld_q && !can_push) begin
        pend_q      <= 1'b1;
        pend_data_q <= rom_data;
      end else if (pend_q && can_push) begin
        pend_q      <= 1'b0;
      end
      if (push) begin
        push_cnt_q <= push_cnt_q + 1'b1;
        for (int t = 0; t < Depth - 1; t++) begin
          sr_q[t] <= nsr[t];
        end
      end
      if (load_win) begin
        win_valid_q <= 1'b1;
        win_data_q  <= win_next;
        win_row_q   <= ctr_row_q;
        win_col_q   <= ctr_col_q;
        if (ctr_col_q == ColLast) begin
          ctr_col_q <= '0;
          ctr_row_q <= ctr_row_q + 1'b1;
        end else begin
          ctr_col_q <= ctr_col_q + 1'b1;
        end
      end else if (win_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

  assign rom_addr  = rd_cnt_q;
  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  // The last window still drains after FLUSH, so busy covers DRAIN too.
  assign busy      = (state_q == StRead) || (state_q == StFlush) || (state_q == StDrain);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: no-stall, random-stall, mid-frame reset, start-while-busy.
module tb_conv_window_gen;
  localparam int PW = 48;
  localparam int W  = 30;
  localparam int H  = 30;
  localparam int WD = 9 * PW;

  logic          clk = 1'b0;
  logic          rst, start, rom_en, win_valid, win_ready, busy, done;
  logic [9:0]    rom_addr;
  logic [PW-1:0] rom_data = '0;
  logic [WD-1:0] win_data;
  logic [4:0]    win_row, win_col;

  conv_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .busy(busy), .done(done));

  always #5 clk = ~clk;

  // ROM returns addr+1 one cycle after rom_en; junk otherwise.
  always @(posedge clk) rom_data <= rom_en ? PW'(rom_addr) + 48'd1 : 48'hBAD0_BAD0_BAD0;

  typedef struct packed {
    logic [4:0]    r;
    logic [4:0]    c;
    logic [WD-1:0] d;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0, n_err = 0;
  int            tick = 0, base = 0;
  int            n_win = 0, done_cnt = 0, done_cyc = 0;
  logic          prev_stall = 1'b0;
  logic [WD-1:0] prev_data;
  logic [9:0]    prev_rc;
  logic [WD-1:0] cap00, cap129, cap2929;

  always @(posedge clk) tick <= tick + 1;

  task automatic chk(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WD-1:0] model(input int r, input int c);
    logic [WD-1:0] v;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int rr, cc, pix;
        rr = r - 1 + i;
        cc = c - 1 + j;
`ifdef WINGEN_EDGE_REPLICATE_EN
        if (rr < 0) rr = 0;
        if (rr >= H) rr = H - 1;
        if (cc < 0) cc = 0;
        if (cc >= W) cc = W - 1;
        pix = rr * W + cc + 1;
`else
        pix = (rr < 0 || rr >= H || cc < 0 || cc >= W) ? 0 : rr * W + cc + 1;
`endif
        v[PW*(3*i+j) +: PW] = PW'(pix);
      end
    end
    return v;
  endfunction

  function automatic logic [WD-1:0] pk9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    logic [WD-1:0] v;
    v = {PW'(a8), PW'(a7), PW'(a6), PW'(a5), PW'(a4), PW'(a3), PW'(a2), PW'(a1), PW'(a0)};
    return v;
  endfunction

  task automatic load_sb();
    sb.delete();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        sb.push_back('{r: 5'(r), c: 5'(c), d: model(r, c)});
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", win_valid, 1);
        chk("hold_data", win_data, prev_data);
        chk("hold_rowcol", {win_row, win_col}, prev_rc);
      end
      if (win_valid && !win_ready) chk("rom_en_during_stall", rom_en, 0);
      if (win_valid && win_ready) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("win_row", win_row, e.r);
          chk("win_col", win_col, e.c);
          chk("win_data", win_data, e.d);
        end
        if (win_row == 5'd0 && win_col == 5'd0) cap00 = win_data;
        if (win_row == 5'd1 && win_col == 5'd29) cap129 = win_data;
        if (win_row == 5'd29 && win_col == 5'd29) cap2929 = win_data;
        n_win++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = tick - base + 1;
      end
      prev_stall = win_valid && !win_ready;
      prev_data  = win_data;
      prev_rc    = {win_row, win_col};
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_win_data"}, win_data, 0);
    chk({tag, "_win_row"}, win_row, 0);
    chk({tag, "_win_col"}, win_col, 0);
    chk({tag, "_rom_en"}, rom_en, 0);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Starts a frame with a full scoreboard and runs it to done (bounded).
  task automatic run_frame(input bit rnd, input bit poke);
    int d0;
    logic [9:0] addr_b;
    load_sb();
    n_win = 0;
    d0 = done_cnt;
    addr_b = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    base = tick;
    start = 1'b0;
    @(negedge clk);
    chk("c1_rom_en", rom_en, 1);
    chk("c1_rom_addr", rom_addr, 0);
    chk("c1_busy", busy, 1);
    for (int k = 0; k < 5000 && done_cnt == d0; k++) begin
      @(posedge clk);
      #1;
      if (rnd) win_ready = 1'($urandom_range(0, 1));
      if (poke && k == 100) begin
        addr_b = rom_addr;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (poke && k == 101) chk("start_busy_no_restart", rom_addr >= addr_b && addr_b > 0, 1);
    end
    win_ready = 1'b1;
    start = 1'b0;
    chk("done_pulses", done_cnt - d0, 1);
    chk("window_count", n_win, 900);
    chk("sb_drained", sb.size(), 0);
    if (!rnd) chk("done_cycle", done_cyc, 934);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    start = 1'b0;
    win_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_frame(1'b0, 1'b0);
`ifdef WINGEN_EDGE_REPLICATE_EN
    chk("win_0_0", cap00, pk9(1, 1, 2, 1, 1, 2, 31, 31, 32));
    chk("win_1_29", cap129, pk9(29, 30, 30, 59, 60, 60, 89, 90, 90));
    chk("win_29_29", cap2929, pk9(869, 870, 870, 899, 900, 900, 899, 900, 900));
`else
    chk("win_0_0", cap00, pk9(0, 0, 0, 0, 1, 2, 0, 31, 32));
    chk("win_1_29", cap129, pk9(29, 30, 0, 59, 60, 0, 89, 90, 0));
    chk("win_29_29", cap2929, pk9(869, 870, 0, 899, 900, 0, 0, 0, 0));
`endif

    run_frame(1'b1, 1'b0);

    // Abort a frame with reset at cycle 400.
    load_sb();
    start = 1'b1;
    @(posedge clk);
    #1;
    base = tick;
    start = 1'b0;
    repeat (399) @(posedge clk);
    #1;
    d0 = done_cnt;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk_zero("midreset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_reset_idle_busy", busy, 0);
    chk("post_reset_idle_rom_en", rom_en, 0);
    chk("no_done_after_abort", done_cnt - d0, 0);
    @(posedge clk);
    #1;

    run_frame(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
